// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC link constants and link transmitter state encoding
package noc_pkg;

  // Defaults shared with the router output fifo so both sides agree on item layout
  localparam int ITEM_SIZE             = 8;
  localparam int ITEM_DESTINATION_BITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } link_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchroniser, clears to 0 on reset
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first one a full cycle to settle
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fifo_link_tx.sv
// rtl/fifo_link_tx.sv - drains a router output fifo onto a 4-phase req/ack link
module fifo_link_tx
  import noc_pkg::*;
#(
  parameter int ID               = -1,
  parameter int SIZE             = ITEM_SIZE,
  parameter int DESTINATION_BITS = ITEM_DESTINATION_BITS,
  parameter bit SYNC_ACK         = 1'b1,
  parameter int COUNT_BITS       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [SIZE-1:0]       fifo_item,
  output logic                  fifo_read,
  output logic                  link_req,
  output logic [SIZE-1:0]       link_data,
  input  logic                  link_ack,
  output logic                  busy,
  output logic [COUNT_BITS-1:0] sent_count,
  output logic                  proto_err
);

  // ID is either unassigned (-1) or a port number; the destination field must
  // leave at least one payload bit above it.
  if (ID < -1 || DESTINATION_BITS < 1 || DESTINATION_BITS >= SIZE) begin : g_bad_params
    $error("fifo_link_tx: invalid ID or DESTINATION_BITS for SIZE");
  end

  logic ack_s;

  if (SYNC_ACK) begin : g_ack_sync
    sync_2ff u_ack_sync (
      .clk   (clk),
      .reset (reset),
      .d     (link_ack),
      .q     (ack_s)
    );
  end else begin : g_ack_raw
    assign ack_s = link_ack;
  end

  link_state_t           state;
  link_state_t           state_nxt;
  logic                  req_nxt;
  logic [SIZE-1:0]       data_nxt;
  logic [COUNT_BITS-1:0] count_nxt;
  logic                  err_nxt;

  // Pop only when the link has returned to zero; REQ is the only state with req high
  assign fifo_read = !reset && !fifo_empty && !ack_s &&
                     (state == ST_IDLE || state == ST_RELEASE);

  assign busy = (state != ST_IDLE);

  // Next-state and next-output logic for the 4-phase handshake
  always_comb begin
    state_nxt = state;
    req_nxt   = link_req;
    data_nxt  = link_data;
    count_nxt = sent_count;
    err_nxt   = proto_err;

    case (state)
      ST_IDLE: begin
        // An ack with no request outstanding means the neighbour misbehaved
        if (ack_s) begin
          err_nxt = 1'b1;
        end
      end
      ST_REQ: begin
        if (ack_s) begin
          req_nxt   = 1'b0;
          state_nxt = ST_RELEASE;
          count_nxt = sent_count + COUNT_BITS'(1);
        end
      end
      ST_RELEASE: begin
        if (!ack_s && fifo_empty) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        req_nxt   = 1'b0;
      end
    endcase

    // A pop loads the item and raises req on the same edge, bypassing IDLE
    // when it comes straight out of RELEASE.
    if (fifo_read) begin
      data_nxt  = fifo_item;
      req_nxt   = 1'b1;
      state_nxt = ST_REQ;
    end
  end

  // State and registered link outputs; reset drops any in-flight item
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      link_req   <= 1'b0;
      link_data  <= '0;
      sent_count <= '0;
      proto_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      link_req   <= req_nxt;
      link_data  <= data_nxt;
      sent_count <= count_nxt;
      proto_err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_link_tx.sv
// tb/tb_fifo_link_tx.sv - scoreboard bench for fifo_link_tx, raw-ack and synchronised-ack instances
module tb_fifo_link_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fifo_empty [2];
  logic       fifo_read  [2];
  logic       link_req   [2];
  logic       link_ack   [2];
  logic       busy       [2];
  logic       proto_err  [2];
  logic [7:0] fifo_item  [2];
  logic [7:0] link_data  [2];
  logic [1:0] sent_count [2];

  logic [7:0] fq    [2][$];
  logic [7:0] exp_q [2][$];
  int         completions [2];
  int         rmax [2];
  int         fmax [2];
  int         cnt  [2];
  int         dly  [2];
  bit         manual [2];
  bit         err_exp [2];
  bit         pop_flag [2];
  logic       prev_req [2];
  logic       prev_read [2];
  logic [7:0] prev_data [2];
  logic       ack_p1 [2];
  logic       ack_p2 [2];
  logic       prev_reset = 1'b1;
  int         pop_cyc [$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  fifo_link_tx #(.ID(0), .SIZE(8), .DESTINATION_BITS(4), .SYNC_ACK(1'b0), .COUNT_BITS(2)) u_raw (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty[0]), .fifo_item(fifo_item[0]),
    .fifo_read(fifo_read[0]), .link_req(link_req[0]), .link_data(link_data[0]),
    .link_ack(link_ack[0]), .busy(busy[0]), .sent_count(sent_count[0]), .proto_err(proto_err[0]));

  fifo_link_tx #(.ID(1), .SIZE(8), .DESTINATION_BITS(4), .SYNC_ACK(1'b1), .COUNT_BITS(2)) u_sync (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty[1]), .fifo_item(fifo_item[1]),
    .fifo_read(fifo_read[1]), .link_req(link_req[1]), .link_data(link_data[1]),
    .link_ack(link_ack[1]), .busy(busy[1]), .sent_count(sent_count[1]), .proto_err(proto_err[1]));

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Stimulus side: the item enters the fifo model and its expected appearance on the link
  task automatic push(input int e, input logic [7:0] v);
    fq[e].push_back(v);
    exp_q[e].push_back(v);
  endtask

  task automatic wait_quiet(input string name);
    int i;
    for (i = 0; i < 800; i++) begin
      if (fq[0].size() == 0 && fq[1].size() == 0 && exp_q[0].size() == 0 &&
          exp_q[1].size() == 0 && !busy[0] && !busy[1]) break;
      step(1);
    end
    chk(name, (i < 800) ? 1 : 0, 1);
  endtask

  // Fifo model and neighbour responder: drive inputs just after each rising edge
  always @(posedge clk) begin
    #1;
    for (int e = 0; e < 2; e++) begin
      if (pop_flag[e] && fq[e].size() > 0) void'(fq[e].pop_front());
      pop_flag[e] = 1'b0;
      if (reset) begin
        link_ack[e] = 1'b0;
        cnt[e] = 0;
      end else if (!manual[e]) begin
        if (link_ack[e] != link_req[e]) begin
          cnt[e]++;
          if (cnt[e] > dly[e]) begin
            link_ack[e] = link_req[e];
            cnt[e] = 0;
            dly[e] = link_req[e] ? $urandom_range(fmax[e], 1) : $urandom_range(rmax[e], 1);
          end
        end else begin
          cnt[e] = 0;
        end
      end
      fifo_empty[e] = (fq[e].size() == 0);
      fifo_item[e]  = fifo_empty[e] ? 8'h00 : fq[e][0];
    end
  end

  // Monitor: link-level rules and scoreboard, sampled on the falling edge
  always @(negedge clk) begin : mon
    logic ack_s_m;
    logic read_exp;
    cyc++;
    for (int e = 0; e < 2; e++) begin
      ack_s_m = (e == 1) ? ack_p2[e] : link_ack[e];
      if (reset) begin
        completions[e] = 0;
        chk("read_in_reset", fifo_read[e], 0);
      end else begin
        read_exp = !fifo_empty[e] && !ack_s_m && !link_req[e];
        chk("fifo_read", fifo_read[e], read_exp);
        if (fifo_read[e] && e == 0) pop_cyc.push_back(cyc);
        if (!prev_reset) begin
          if (link_req[e] && !prev_req[e]) begin
            chk("pop_to_req", prev_read[e], 1);
            if (exp_q[e].size() == 0) chk("req_without_item", 1, 0);
            else chk("link_data", link_data[e], exp_q[e].pop_front());
          end
          if (!link_req[e] && prev_req[e]) begin
            completions[e]++;
            chk("sent_count", sent_count[e], completions[e] % 4);
          end
          if (link_data[e] != prev_data[e]) chk("data_only_on_pop", prev_read[e], 1);
        end
        chk("proto_err", proto_err[e], err_exp[e]);
      end
      pop_flag[e]  = fifo_read[e] && !reset;
      prev_req[e]  = link_req[e];
      prev_read[e] = fifo_read[e];
      prev_data[e] = link_data[e];
      ack_p2[e]    = ack_p1[e];
      ack_p1[e]    = link_ack[e];
    end
    prev_reset = reset;
  end

  initial begin : main
    int i;
    for (int e = 0; e < 2; e++) begin
      fifo_empty[e] = 1'b1; fifo_item[e] = 8'h00; link_ack[e] = 1'b0;
      rmax[e] = 1; fmax[e] = 1; dly[e] = 1; cnt[e] = 0;
      manual[e] = 1'b0; err_exp[e] = 1'b0; pop_flag[e] = 1'b0;
      prev_req[e] = 1'b0; prev_read[e] = 1'b0; prev_data[e] = 8'h00;
      ack_p1[e] = 1'b0; ack_p2[e] = 1'b0; completions[e] = 0;
    end

    // Reset state
    reset = 1'b1;
    step(4);
    for (int e = 0; e < 2; e++) begin
      chk("reset_req", link_req[e], 0);
      chk("reset_data", link_data[e], 0);
      chk("reset_busy", busy[e], 0);
      chk("reset_count", sent_count[e], 0);
      chk("reset_perr", proto_err[e], 0);
    end
    reset = 1'b0;
    step(5);

    // Single item, responder with one cycle of ack delay
    push(0, 8'hA3);
    for (i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (fifo_read[0]) break;
    end
    chk("t2_pop_seen", (i < 20) ? 1 : 0, 1);
    @(negedge clk); #1;
    chk("t2_req_next", link_req[0], 1);
    chk("t2_data", link_data[0], 8'hA3);
    repeat (3) @(negedge clk);
    #1;
    chk("t2_busy_before", busy[0], 1);
    @(negedge clk); #1;
    chk("t2_busy_fall", busy[0], 0);
    chk("t2_count", sent_count[0], 1);
    step(2);

    // Three queued items go out back to back every four cycles
    pop_cyc.delete();
    push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
    for (i = 0; i < 60 && pop_cyc.size() < 3; i++) step(1);
    chk("t3_pops", pop_cyc.size(), 3);
    if (pop_cyc.size() == 3) begin
      chk("t3_spacing_a", pop_cyc[1] - pop_cyc[0], 4);
      chk("t3_spacing_b", pop_cyc[2] - pop_cyc[1], 4);
    end
    wait_quiet("t3_drain");
    chk("t3_count_wrap", sent_count[0], 0);

    // Spurious ack in IDLE: sticky error, pop held off while ack is high
    manual[0] = 1'b1;
    link_ack[0] = 1'b1;
    step(1);
    err_exp[0] = 1'b1;
    push(0, 8'h5C);
    step(4);
    chk("t5_no_pop", fq[0].size(), 1);
    link_ack[0] = 1'b0;
    manual[0] = 1'b0;
    wait_quiet("t5_drain");
    chk("t5_perr_sticky", proto_err[0], 1);
    chk("t7_count_wrap", sent_count[0], 1);

    // Randomised traffic on both instances, including long ack hold times
    for (int seg = 0; seg < 4; seg++) begin
      for (int e = 0; e < 2; e++) begin
        rmax[e] = $urandom_range(3, 1);
        fmax[e] = (seg == 1) ? 12 : $urandom_range(4, 1);
      end
      for (int c = 0; c < 100; c++) begin
        for (int e = 0; e < 2; e++)
          if ($urandom_range(3, 0) == 0 && fq[e].size() < 6) push(e, 8'($urandom));
        step(1);
      end
    end
    wait_quiet("rand_drain");

    // Reset while a request is outstanding
    rmax[0] = 5; fmax[0] = 2; dly[0] = 5;
    push(0, 8'h77);
    for (i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (link_req[0]) break;
    end
    chk("t6_req_seen", (i < 40) ? 1 : 0, 1);
    reset = 1'b1;
    err_exp[0] = 1'b0;
    @(negedge clk); #1;
    chk("t6_req_drop", link_req[0], 0);
    chk("t6_busy", busy[0], 0);
    chk("t6_count", sent_count[0], 0);
    chk("t6_perr_clear", proto_err[0], 0);
    step(3);
    reset = 1'b0;
    rmax[0] = 2;
    step(2);
    push(0, 8'h88);
    wait_quiet("t6_drain");
    chk("t6_count_after", sent_count[0], 1);
    chk("t6_fifo_kept", fq[0].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
